// File: rtl/md_ctrl_if.sv
// Handshake/bus bundle between the E/D pipeline stages and the multiply/divide controller.
interface md_ctrl_if;
    logic [31:0] Instr_FD;
    logic [31:0] Instr_DE;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        start;
    logic        md_stall;

    // Pipeline side: drives instructions/operands, consumes HI/LO and stall.
    modport master (
        output Instr_FD, Instr_DE, RS_E, RT_E,
        input  HI, LO, busy, start, md_stall
    );

    // Controller side.
    modport slave (
        input  Instr_FD, Instr_DE, RS_E, RT_E,
        output HI, LO, busy, start, md_stall
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI/LO, with mthi/mtlo and a D-stage stall.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic [31:0] r_hi, w_hi_d;
    logic [31:0] r_lo, w_lo_d;
    logic [31:0] r_hi_p, w_hi_p_d;
    logic [31:0] r_lo_p, w_lo_p_d;

    logic        w_start;
    logic        w_busy;

    // E-stage decode
    logic        w_de_r;
    logic [5:0]  w_de_f;
    logic        w_de_mult, w_de_multu, w_de_div, w_de_divu, w_de_mthi, w_de_mtlo;
    logic        w_de_md, w_de_mul_any, w_div_zero;
    logic        w_fd_hilo;

    assign w_de_r       = (bus.Instr_DE[31:26] == 6'b000000);
    assign w_de_f       = bus.Instr_DE[5:0];
    assign w_de_mult    = w_de_r && (w_de_f == 6'b011000);
    assign w_de_multu   = w_de_r && (w_de_f == 6'b011001);
    assign w_de_div     = w_de_r && (w_de_f == 6'b011010);
    assign w_de_divu    = w_de_r && (w_de_f == 6'b011011);
    assign w_de_mthi    = w_de_r && (w_de_f == 6'b010001);
    assign w_de_mtlo    = w_de_r && (w_de_f == 6'b010011);
    assign w_de_mul_any = w_de_mult | w_de_multu;
    assign w_de_md      = w_de_mult | w_de_multu | w_de_div | w_de_divu;
    assign w_div_zero   = (w_de_div | w_de_divu) && (bus.RT_E == 32'd0);

    // funct 0100xx covers mfhi/mthi/mflo/mtlo, 0110xx covers mult/multu/div/divu
    assign w_fd_hilo = (bus.Instr_FD[31:26] == 6'b000000) &&
                       ((bus.Instr_FD[5:2] == 4'b0100) || (bus.Instr_FD[5:2] == 4'b0110));

    // Arithmetic datapath
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_den, w_q_mag, w_r_mag, w_q, w_r;
    logic [31:0] w_hi_res, w_lo_res;

    assign w_prod_s = {{32{bus.RS_E[31]}}, bus.RS_E} * {{32{bus.RT_E[31]}}, bus.RT_E};
    assign w_prod_u = {32'd0, bus.RS_E} * {32'd0, bus.RT_E};

    // Signed divide via magnitudes; the -2^31 / -1 case wraps to 0x80000000 naturally.
    assign w_a_neg = w_de_div && bus.RS_E[31];
    assign w_b_neg = w_de_div && bus.RT_E[31];
    assign w_a_mag = w_a_neg ? (~bus.RS_E + 32'd1) : bus.RS_E;
    assign w_b_mag = w_b_neg ? (~bus.RT_E + 32'd1) : bus.RT_E;
    // Zero divisor is replaced so the divider never sees it; result is discarded anyway.
    assign w_b_den = (bus.RT_E == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_den;
    assign w_r_mag = w_a_mag % w_b_den;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Select the result to latch into the pending registers
    always_comb begin
        w_hi_res = w_r;
        w_lo_res = w_q;
        if (w_de_mult) begin
            w_hi_res = w_prod_s[63:32];
            w_lo_res = w_prod_s[31:0];
        end else if (w_de_multu) begin
            w_hi_res = w_prod_u[63:32];
            w_lo_res = w_prod_u[31:0];
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_p  <= 32'd0;
            r_lo_p  <= 32'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
            r_hi_p  <= w_hi_p_d;
            r_lo_p  <= w_lo_p_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_hi_d    = r_hi;
        w_lo_d    = r_lo;
        w_hi_p_d  = r_hi_p;
        w_lo_p_d  = r_lo_p;
        w_start   = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_de_md) begin
                    w_start   = 1'b1;
                    // Divide by zero re-commits the current HI/LO, leaving them unchanged.
                    w_hi_p_d  = w_div_zero ? r_hi : w_hi_res;
                    w_lo_p_d  = w_div_zero ? r_lo : w_lo_res;
                    w_cnt_d   = w_de_mul_any ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    w_state_d = StRun;
                end else if (w_de_mthi) begin
                    w_hi_d = bus.RS_E;
                end else if (w_de_mtlo) begin
                    w_lo_d = bus.RS_E;
                end
            end
            StRun: begin
                // HI/LO writers arriving here are ignored by construction.
                w_busy  = 1'b1;
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_hi_d    = r_hi_p;
                    w_lo_d    = r_lo_p;
                    w_state_d = StIdle;
                end
            end
        endcase
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.busy     = w_busy;
    assign bus.start    = w_start;
    assign bus.md_stall = (w_start | w_busy) & w_fd_hilo;
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the five-stage MIPS pipeline. It sequences multi-cycle mult/multu/div/divu operations issued from the E stage, owns the HI/LO registers, and executes mthi/mtlo. It also raises a D-stage stall request for any HI/LO-related instruction while the unit is occupied. The top level ORs that request into the existing hazard stall.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy duration of mult/multu, range 1..15.
- DIV_CYCLES, default 10: busy duration of div/divu, range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; when 0 at a rising edge, all state clears.
- Instr_FD  in  32  instruction currently in D.
- Instr_DE  in  32  instruction currently in E. A bubble is 32'h0.
- RS_E  in  32  forwarded rs operand in E.
- RT_E  in  32  forwarded rt operand in E.
- HI  out  32  architectural HI register; reset 0.
- LO  out  32  architectural LO register; reset 0.
- busy  out  1  operation in progress; reset 0.
- start  out  1  combinational; 1 in the cycle a mult/div is accepted from E.
- md_stall  out  1  combinational; D-stage stall request.

## Operation
- **Decode:** opcode 6'b000000 plus funct:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mthi 010001, mtlo 010011, mfhi 010000, mflo 010010
- **States:** IDLE, RUN. A 4-bit counter `cnt` plus 32-bit pending registers `hi_p` and `lo_p` hold the result.
- **IDLE:**
  - If Instr_DE is mult/multu/div/divu, then `start`=1.
  - At the edge: compute the result from RS_E and RT_E into `hi_p`/`lo_p`, load `cnt` with MULT_CYCLES or DIV_CYCLES, and go to RUN.
- **RUN:**
  - `busy`=1.
  - `cnt` decrements each edge.
  - On the edge where `cnt`==1: copy `hi_p`→HI and `lo_p`→LO, then go to IDLE.
- **mthi/mtlo in E while IDLE:** HI (resp. LO) ← RS_E at the edge. Single cycle, no busy.
- **Arithmetic:**
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64, {HI,LO}=product.
  - div: signed; LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned; same LO/HI assignment.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- **Divisor 0:** the full DIV_CYCLES busy sequence still runs; at completion HI and LO keep their prior values.
- **md_stall** = (`start` | `busy`) & (Instr_FD is any of the eight HI/LO instructions).
- **mfhi/mflo:** the E-stage result mux reads HI/LO directly. This block adds no stall beyond md_stall.
- **Illegal issue:** any HI/LO-writing instruction present in E while `busy`=1 is ignored: no state change, `start`=0. md_stall makes this unreachable, and the bench asserts that it never occurs.
- **Reset:**
  - Applies mid-operation: state→IDLE, `cnt`=0, HI=LO=`hi_p`=`lo_p`=0.
  - The pending result is discarded and never committed.
- Other instructions in E or D (including bgez/bltz, opcode 000001) have no effect.

## Timing
- **Accepted op at cycle T** (E holds mult/div, IDLE):
  - `start`=1 in T only.
  - `busy`=1 in cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO hold the new value from T+N+1.
- **md_stall for a HI/LO instruction in D:**
  - Asserted in T .. T+N.
  - Deasserts at T+N+1, so an mfhi/mflo held in D reaches E no earlier than T+N+2 and sees the new value.
- **Back-to-back issue:** a new mult/div may be accepted at T+N+1 (state is IDLE again). There is no idle gap.
- **mthi/mtlo at cycle T:** the value is visible on HI/LO from T+1.
- Output latency of HI/LO is register-direct (zero combinational delay from state).
- Reset takes effect on the first rising edge with `reset`=0. Outputs are at reset values from the following cycle; `start` and `md_stall` are 0 while state is reset and decode is idle.

## Test plan
1. **Reset:** hold `reset`=0 for 1 edge → HI=0, LO=0, `busy`=0, `start`=0. Then a bubble stream with `reset`=1 → all outputs stay 0.
2. **mult/multu:**
   - mult, RS_E=0xFFFFFFFF, RT_E=2 at T → `start`=1@T, `busy`=1 @T+1..T+5, HI=0xFFFFFFFF and LO=0xFFFFFFFE @T+6.
   - multu, same operands → HI=0x00000001, LO=0xFFFFFFFE.
3. **div/divu:**
   - div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after exactly 10 busy cycles.
   - divu 7/2 → LO=3, HI=1.
   - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. **Stall window:**
   - mult in E at T, mflo held in D → `md_stall`=1 @T..T+5, 0 @T+6.
   - addu in D during the same window → `md_stall`=0.
   - mflo reaching E at T+7 → LO shows the product.
5. **Divide by zero:** mthi 0x12345678, then mtlo 0x9ABCDEF0, then div x/0 → `busy` for 10 cycles, HI=0x12345678 and LO=0x9ABCDEF0 unchanged afterwards.
6. **Reset mid-op:** mult 3×4 at T, `reset`=0 at the T+3 edge → `busy`=0 and HI=LO=0 from T+4, and no commit of 12 at T+6 or later.
